// File: rtl/nonce_search_ctrl_if.sv
// Hash-core link of the nonce search controller: the block issued for hashing
// plus the hash result coming back.
interface nonce_search_ctrl_if #(
    parameter int HDR_BYTES   = 12,
    parameter int NONCE_BYTES = 4,
    parameter int HASH_BYTES  = 3
);
    logic [8*(HDR_BYTES+NONCE_BYTES)-1:0] blk_out;
    logic                                 blk_valid;
    logic [8*HASH_BYTES-1:0]              hash_in;
    logic                                 hash_valid;

    // Controller side: issues blocks, consumes hashes.
    modport master (
        output blk_out,
        output blk_valid,
        input  hash_in,
        input  hash_valid
    );

    // Hash-core side: consumes blocks, returns hashes.
    modport slave (
        input  blk_out,
        input  blk_valid,
        output hash_in,
        output hash_valid
    );
endinterface

// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: walks an inclusive (possibly wrapping) nonce range,
// issues {header, nonce} blocks to the hash core, compares the top target
// bytes of each returned hash against a threshold and reports the first
// winner, range exhaustion or a hash-core timeout. All outputs are registered.
module nonce_search_ctrl #(
    parameter int HDR_BYTES   = 12,
    parameter int NONCE_BYTES = 4,
    parameter int HASH_BYTES  = 3,
    parameter int TGT_BYTES   = 1,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [8*HDR_BYTES-1:0]    header,
    input  logic [8*NONCE_BYTES-1:0]  nonce_start,
    input  logic [8*NONCE_BYTES-1:0]  nonce_limit,
    input  logic [8*TGT_BYTES-1:0]    target,
    nonce_search_ctrl_if.master       hc,
    output logic                      busy,
    output logic                      found,
    output logic                      exhausted,
    output logic                      timeout_err,
    output logic [8*NONCE_BYTES-1:0]  nonce_found,
    output logic [8*HASH_BYTES-1:0]   hash_found,
    output logic [CNT_W-1:0]          attempts
);
    localparam int HDR_W   = 8 * HDR_BYTES;
    localparam int NONCE_W = 8 * NONCE_BYTES;
    localparam int HASH_W  = 8 * HASH_BYTES;
    localparam int TGT_W   = 8 * TGT_BYTES;
    localparam int BLK_W   = HDR_W + NONCE_W;
    localparam int WCNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q,       state_d;
    logic [HDR_W-1:0]    header_q,      header_d;
    logic [NONCE_W-1:0]  nonce_q,       nonce_d;
    logic [NONCE_W-1:0]  limit_q,       limit_d;
    logic [TGT_W-1:0]    target_q,      target_d;
    logic [HASH_W-1:0]   hash_q,        hash_d;
    logic [WCNT_W-1:0]   wait_cnt_q,    wait_cnt_d;
    logic [BLK_W-1:0]    blk_out_q,     blk_out_d;
    logic                blk_valid_q,   blk_valid_d;
    logic                busy_q,        busy_d;
    logic                found_q,       found_d;
    logic                exhausted_q,   exhausted_d;
    logic                timeout_err_q, timeout_err_d;
    logic [NONCE_W-1:0]  nonce_found_q, nonce_found_d;
    logic [HASH_W-1:0]   hash_found_q,  hash_found_d;
    logic [CNT_W-1:0]    attempts_q,    attempts_d;

    logic                win_s;
    logic                at_limit_s;

    // Win: top target bytes of the captured hash strictly below the threshold.
    always_comb begin
        win_s      = (hash_q[HASH_W-1 -: TGT_W] < target_q);
        at_limit_s = (nonce_q == limit_q);
    end

    // Next-state and output computation; abort overrides every other decision.
    always_comb begin
        state_d       = state_q;
        header_d      = header_q;
        nonce_d       = nonce_q;
        limit_d       = limit_q;
        target_d      = target_q;
        hash_d        = hash_q;
        wait_cnt_d    = wait_cnt_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        timeout_err_d = timeout_err_q;
        nonce_found_d = nonce_found_q;
        hash_found_d  = hash_found_q;
        attempts_d    = attempts_q;
        blk_valid_d   = 1'b0;
        blk_out_d     = blk_out_q;
        busy_d        = 1'b0;

        if (abort) begin
            state_d       = ST_IDLE;
            found_d       = 1'b0;
            exhausted_d   = 1'b0;
            timeout_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        header_d      = header;
                        nonce_d       = nonce_start;
                        limit_d       = nonce_limit;
                        target_d      = target;
                        found_d       = 1'b0;
                        exhausted_d   = 1'b0;
                        timeout_err_d = 1'b0;
                        attempts_d    = '0;
                        state_d       = ST_ISSUE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    if (hc.hash_valid) begin
                        hash_d  = hc.hash_in;
                        state_d = ST_CHECK;
                    end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
                        timeout_err_d = 1'b1;
                        nonce_found_d = nonce_q;
                        state_d       = ST_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1'b1);
                    end
                end
                ST_CHECK: begin
                    if (attempts_q == '1) begin
                        attempts_d = attempts_q;
                    end else begin
                        attempts_d = attempts_q + CNT_W'(1'b1);
                    end
                    if (win_s) begin
                        found_d       = 1'b1;
                        nonce_found_d = nonce_q;
                        hash_found_d  = hash_q;
                        state_d       = ST_DONE;
                    end else if (at_limit_s) begin
                        exhausted_d   = 1'b1;
                        nonce_found_d = nonce_q;
                        hash_found_d  = hash_q;
                        state_d       = ST_DONE;
                    end else begin
                        nonce_d = nonce_q + NONCE_W'(1'b1);
                        state_d = ST_ISSUE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Block and valid are registered so they appear exactly in the ISSUE cycle.
        if (state_d == ST_ISSUE) begin
            blk_valid_d = 1'b1;
            blk_out_d   = {header_d, nonce_d};
        end else begin
            blk_valid_d = 1'b0;
            blk_out_d   = blk_out_q;
        end

        if ((state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_CHECK)) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            header_q      <= '0;
            nonce_q       <= '0;
            limit_q       <= '0;
            target_q      <= '0;
            hash_q        <= '0;
            wait_cnt_q    <= '0;
            blk_out_q     <= '0;
            blk_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            nonce_found_q <= '0;
            hash_found_q  <= '0;
            attempts_q    <= '0;
        end else begin
            state_q       <= state_d;
            header_q      <= header_d;
            nonce_q       <= nonce_d;
            limit_q       <= limit_d;
            target_q      <= target_d;
            hash_q        <= hash_d;
            wait_cnt_q    <= wait_cnt_d;
            blk_out_q     <= blk_out_d;
            blk_valid_q   <= blk_valid_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            timeout_err_q <= timeout_err_d;
            nonce_found_q <= nonce_found_d;
            hash_found_q  <= hash_found_d;
            attempts_q    <= attempts_d;
        end
    end

    assign hc.blk_out   = blk_out_q;
    assign hc.blk_valid = blk_valid_q;
    assign busy         = busy_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign timeout_err  = timeout_err_q;
    assign nonce_found  = nonce_found_q;
    assign hash_found   = hash_found_q;
    assign attempts     = attempts_q;
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl: a default-width instance driven through
// win / exhaust / wrap / target-0 / timeout / abort / async-reset scenarios, and a
// wide-nonce instance for the 8-byte header/nonce, 2-byte target configuration.
module tb_nonce_search_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   errors = 0;
    int   checks = 0;

    // Default-width instance
    logic        start, abort;
    logic [95:0] header;
    logic [31:0] nonce_start, nonce_limit;
    logic [7:0]  target;
    logic        busy, found, exhausted, timeout_err;
    logic [31:0] nonce_found;
    logic [23:0] hash_found;
    logic [31:0] attempts;

    nonce_search_ctrl_if #(.HDR_BYTES(12), .NONCE_BYTES(4), .HASH_BYTES(3)) hc ();

    nonce_search_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .header(header), .nonce_start(nonce_start), .nonce_limit(nonce_limit),
        .target(target), .hc(hc), .busy(busy), .found(found),
        .exhausted(exhausted), .timeout_err(timeout_err),
        .nonce_found(nonce_found), .hash_found(hash_found), .attempts(attempts)
    );

    // Wide instance: 8-byte header, 8-byte nonce, 2-byte target
    logic         start2, abort2;
    logic [63:0]  header2;
    logic [63:0]  nonce_start2, nonce_limit2;
    logic [15:0]  target2;
    logic         busy2, found2, exhausted2, timeout_err2;
    logic [63:0]  nonce_found2;
    logic [23:0]  hash_found2;
    logic [31:0]  attempts2;
    logic [63:0]  win2;

    nonce_search_ctrl_if #(.HDR_BYTES(8), .NONCE_BYTES(8), .HASH_BYTES(3)) hc2 ();

    nonce_search_ctrl #(.HDR_BYTES(8), .NONCE_BYTES(8), .HASH_BYTES(3), .TGT_BYTES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .header(header2), .nonce_start(nonce_start2), .nonce_limit(nonce_limit2),
        .target(target2), .hc(hc2), .busy(busy2), .found(found2),
        .exhausted(exhausted2), .timeout_err(timeout_err2),
        .nonce_found(nonce_found2), .hash_found(hash_found2), .attempts(attempts2)
    );

    // Hash model, latency 1: 0x10 top byte for the winning nonce, else 0xFF.
    logic        model_en;
    logic        win_en;
    logic [31:0] win_nonce;
    always @(posedge clk) begin
        hc.hash_valid <= 1'b0;
        if (hc.blk_valid && model_en) begin
            hc.hash_valid <= 1'b1;
            if (win_en && (hc.blk_out[31:0] == win_nonce))
                hc.hash_in <= {8'h10, hc.blk_out[15:0]};
            else
                hc.hash_in <= {8'hFF, hc.blk_out[15:0]};
        end
    end

    // Hash model for the wide instance: 0x00FF55 for win2, else 0xFFFF00.
    always @(posedge clk) begin
        hc2.hash_valid <= 1'b0;
        if (hc2.blk_valid) begin
            hc2.hash_valid <= 1'b1;
            hc2.hash_in    <= (hc2.blk_out[63:0] == win2) ? 24'h00FF55 : 24'hFFFF00;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected nonces queued with the stimulus, popped per blk_valid.
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          blk_cnt = 0;
    always @(negedge clk) begin
        if (reset && hc.blk_valid) begin
            blk_cnt++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL blk_unexpected: observed blk_out=%0h expected no blk_valid", hc.blk_out);
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                chk("blk_out", {32'h0, hc.blk_out}, {32'h0, header, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [31:0] first, input int n);
        logic [31:0] v;
        v = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            v = v + 32'd1;
        end
    endtask

    // Start a search and count cycles until a result flag rises (bounded).
    task automatic run(input logic [31:0] s, input logic [31:0] l,
                       input logic [7:0] t, output int cyc);
        nonce_start = s;
        nonce_limit = l;
        target      = t;
        start       = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!(found || exhausted || timeout_err) && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    int snap;

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        header = 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4;
        nonce_start = 32'h0; nonce_limit = 32'h0; target = 8'h0;
        start2 = 1'b0; abort2 = 1'b0;
        header2 = 64'hDEAD_BEEF_0BAD_F00D;
        nonce_start2 = 64'h0; nonce_limit2 = 64'h0; target2 = 16'h0;
        win2 = 64'h0;
        model_en = 1'b1; win_en = 1'b1; win_nonce = 32'd5;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {found, exhausted, timeout_err}, 3'b000);
        chk("rst_blk", {hc.blk_valid, hc.blk_out}, 129'h0);
        chk("rst_attempts", attempts, 32'h0);
        reset = 1'b1;
        tick();

        // Winner at nonce 5 of 0..9
        blk_cnt = 0;
        push_range(32'd0, 6);
        run(32'd0, 32'd9, 8'h20, cyc);
        chk("win_found", {found, exhausted, timeout_err, busy}, 4'b1000);
        chk("win_nonce", nonce_found, 32'd5);
        chk("win_hash", hash_found, 24'h100005);
        chk("win_attempts", attempts, 32'd6);
        chk("win_cycles", cyc, 19);
        chk("win_blk_cnt", blk_cnt, 6);
        chk("win_q_empty", exp_q.size(), 0);

        // No winner over 0..9 (restart from DONE)
        win_en = 1'b0;
        push_range(32'd0, 10);
        run(32'd0, 32'd9, 8'h20, cyc);
        chk("exh_flags", {found, exhausted, timeout_err, busy}, 4'b0100);
        chk("exh_nonce", nonce_found, 32'd9);
        chk("exh_hash", hash_found, 24'hFF0009);
        chk("exh_attempts", attempts, 32'd10);
        chk("exh_cycles", cyc, 31);

        // Wrap-around FFFFFFFE .. 1
        push_range(32'hFFFF_FFFE, 4);
        run(32'hFFFF_FFFE, 32'h0000_0001, 8'h20, cyc);
        chk("wrap_flags", {found, exhausted}, 2'b01);
        chk("wrap_attempts", attempts, 32'd4);
        chk("wrap_nonce", nonce_found, 32'd1);
        chk("wrap_q_empty", exp_q.size(), 0);

        // Single-attempt range, target 0 never wins even on a low hash
        win_en = 1'b1; win_nonce = 32'd7;
        push_range(32'd7, 1);
        run(32'd7, 32'd7, 8'h00, cyc);
        chk("t0_flags", {found, exhausted}, 2'b01);
        chk("t0_attempts", attempts, 32'd1);
        chk("t0_hash", hash_found, 24'h100007);

        // Silent hash core: timeout TIMEOUT+1 cycles after blk_valid
        model_en = 1'b0;
        push_range(32'd3, 1);
        nonce_start = 32'd3; nonce_limit = 32'd9; target = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_blk_valid", hc.blk_valid, 1'b1);
        cyc = 0;
        while (!timeout_err && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("to_cycles", cyc, 65);
        chk("to_flags", {timeout_err, found, exhausted, busy}, 4'b1000);
        chk("to_attempts", attempts, 32'd0);

        // Abort coincident with the winning hash of the second attempt
        model_en = 1'b1; win_en = 1'b1; win_nonce = 32'd1;
        push_range(32'd0, 2);
        nonce_start = 32'd0; nonce_limit = 32'd9; target = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_flags", {found, exhausted, timeout_err, busy}, 4'b0000);
        chk("abort_attempts", attempts, 32'd1);
        snap = blk_cnt;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_no_blk", blk_cnt, snap);
        chk("abort_found_low", found, 1'b0);

        // Asynchronous reset in the middle of WAIT
        model_en = 1'b0;
        push_range(32'd2, 1);
        nonce_start = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("areset_flags", {busy, found, exhausted, timeout_err}, 4'b0000);
        chk("areset_blk", {hc.blk_valid, hc.blk_out}, 129'h0);
        chk("areset_outs", {nonce_found, hash_found, attempts}, 88'h0);
        #2;
        reset = 1'b1;
        snap = blk_cnt;
        for (int i = 0; i < 10; i++) tick();
        chk("areset_no_blk", blk_cnt, snap);

        // Wide configuration: 64-bit nonce, 2-byte target
        nonce_start2 = 64'h1122_3344_5566_7788;
        nonce_limit2 = 64'h1122_3344_5566_778D;
        win2         = 64'h1122_3344_5566_778A;
        target2      = 16'h0100;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 1;
        while (!(found2 || exhausted2 || timeout_err2) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("w_flags", {found2, exhausted2, timeout_err2, busy2}, 4'b1000);
        chk("w_nonce", nonce_found2, 64'h1122_3344_5566_778A);
        chk("w_hash", hash_found2, 24'h00FF55);
        chk("w_attempts", attempts2, 32'd3);
        chk("w_blk_out", hc2.blk_out, {64'hDEAD_BEEF_0BAD_F00D, 64'h1122_3344_5566_778A});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
